// File: rtl/ps2_pkg.sv
// Shared types, frame constants and the parity helper for the PS/2 host receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam int         PS2_FRAME_BITS = 11;
  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  // Odd parity holds when the data bits and the parity bit XOR to 1.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_rx_sync_filter.sv
// Synchronises ps2_clk/ps2_dat, deglitches ps2_clk over FILTER_LEN samples and
// emits a one-cycle fall_pulse on each filtered falling edge of ps2_clk.
module ps2_rx_sync_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic fall_pulse,
  output logic dat
);

  localparam logic [3:0] FLEN = 4'(FILTER_LEN);

  logic       clk_s1;
  logic       clk_s2;
  logic       dat_s1;
  logic       dat_s2;
  logic       clk_filt;
  logic [3:0] filt_cnt;

  // Synchronisers, ps2_clk level filter and falling-edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1     <= 1'b1;
      clk_s2     <= 1'b1;
      dat_s1     <= 1'b1;
      dat_s2     <= 1'b1;
      clk_filt   <= 1'b1;
      filt_cnt   <= 4'd0;
      fall_pulse <= 1'b0;
    end else begin
      clk_s1     <= ps2_clk;
      clk_s2     <= clk_s1;
      dat_s1     <= ps2_dat;
      dat_s2     <= dat_s1;
      fall_pulse <= 1'b0;
      if (clk_s2 == clk_filt) begin
        filt_cnt <= 4'd0;
      end else if (filt_cnt + 4'd1 == FLEN) begin
        // Enough consecutive differing samples: accept the new level.
        clk_filt   <= clk_s2;
        filt_cnt   <= 4'd0;
        fall_pulse <= ~clk_s2;
      end else begin
        filt_cnt <= filt_cnt + 4'd1;
      end
    end
  end

  assign dat = dat_s2;

endmodule

// File: rtl/ps2_host_rx.sv
// PS/2 host receiver: deserialises START, d0..d7, odd parity, STOP frames into bytes.
// Optional prefix decoding (E0 / F0) is enabled by defining PS2_BREAK_DECODE_EN.
module ps2_host_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_data,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       key_release,
  output logic       key_ext
);

  localparam logic [15:0] TMO      = 16'(TIMEOUT);
  localparam logic [3:0]  LAST_BIT = 4'(PS2_FRAME_BITS - 2);

  logic        fall_pulse;
  logic        dat;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  bit_cnt;
  logic [3:0]  bit_cnt_nxt;
  logic [15:0] tmo_cnt;
  logic [15:0] tmo_nxt;
  logic [9:0]  shreg;
  logic [9:0]  shreg_nxt;
  logic [7:0]  rx_data_nxt;
  logic        dv_nxt;
  logic        pe_nxt;
  logic        fe_nxt;
  logic        kr_nxt;
  logic        ke_nxt;

`ifdef PS2_BREAK_DECODE_EN
  logic        ext;
  logic        ext_nxt;
  logic        brk;
  logic        brk_nxt;
`endif

  ps2_rx_sync_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_sync_filter (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .fall_pulse(fall_pulse),
    .dat       (dat)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, datapath and output-pulse decode.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    tmo_nxt     = tmo_cnt;
    shreg_nxt   = shreg;
    rx_data_nxt = rx_data;
    dv_nxt      = 1'b0;
    pe_nxt      = 1'b0;
    fe_nxt      = 1'b0;
    kr_nxt      = 1'b0;
    ke_nxt      = 1'b0;
`ifdef PS2_BREAK_DECODE_EN
    ext_nxt     = ext;
    brk_nxt     = brk;
`endif
    case (state)
      IDLE: begin
        if (fall_pulse && !dat) begin
          state_nxt   = RECV;
          bit_cnt_nxt = 4'd0;
          tmo_nxt     = 16'd0;
        end else begin
          state_nxt = IDLE;
        end
      end
      RECV: begin
        if (fall_pulse) begin
          shreg_nxt = {dat, shreg[9:1]};
          tmo_nxt   = 16'd0;
          if (bit_cnt == LAST_BIT) begin
            state_nxt = CHECK;
          end else begin
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
        end else if (tmo_cnt >= TMO) begin
          fe_nxt    = 1'b1;
          state_nxt = IDLE;
`ifdef PS2_BREAK_DECODE_EN
          ext_nxt   = 1'b0;
          brk_nxt   = 1'b0;
`endif
        end else if (tmo_cnt != 16'hFFFF) begin
          tmo_nxt = tmo_cnt + 16'd1;
        end else begin
          tmo_nxt = tmo_cnt;
        end
      end
      CHECK: begin
        state_nxt = IDLE;
        if (!shreg[9]) begin
          fe_nxt  = 1'b1;
`ifdef PS2_BREAK_DECODE_EN
          ext_nxt = 1'b0;
          brk_nxt = 1'b0;
`endif
        end else if (!odd_parity_ok(shreg[7:0], shreg[8])) begin
          pe_nxt      = 1'b1;
          rx_data_nxt = shreg[7:0];
`ifdef PS2_BREAK_DECODE_EN
          ext_nxt     = 1'b0;
          brk_nxt     = 1'b0;
`endif
        end else begin
          rx_data_nxt = shreg[7:0];
`ifdef PS2_BREAK_DECODE_EN
          // Prefix bytes only arm a flag; the following key byte carries it out.
          if (shreg[7:0] == PS2_PREFIX_EXT) begin
            ext_nxt = 1'b1;
          end else if (shreg[7:0] == PS2_PREFIX_BRK) begin
            brk_nxt = 1'b1;
          end else begin
            dv_nxt  = 1'b1;
            ke_nxt  = ext;
            kr_nxt  = brk;
            ext_nxt = 1'b0;
            brk_nxt = 1'b0;
          end
`else
          dv_nxt = 1'b1;
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath registers and registered output pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt     <= 4'd0;
      tmo_cnt     <= 16'd0;
      shreg       <= 10'd0;
      rx_data     <= 8'd0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      key_release <= 1'b0;
      key_ext     <= 1'b0;
    end else begin
      bit_cnt     <= bit_cnt_nxt;
      tmo_cnt     <= tmo_nxt;
      shreg       <= shreg_nxt;
      rx_data     <= rx_data_nxt;
      data_valid  <= dv_nxt;
      parity_err  <= pe_nxt;
      frame_err   <= fe_nxt;
      key_release <= kr_nxt;
      key_ext     <= ke_nxt;
    end
  end

`ifdef PS2_BREAK_DECODE_EN
  // Prefix flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else begin
      ext <= ext_nxt;
      brk <= brk_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_ps2_host_rx.sv
// Scoreboard bench for ps2_host_rx: a bench model queues expected pulses per frame,
// a negedge monitor pops and compares them whenever the DUT emits a pulse.
module tb_ps2_host_rx;

  localparam int FILTER_LEN = 2;
  localparam int TIMEOUT    = 64;

  logic       clk;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] rx_data;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       key_release;
  logic       key_ext;

  typedef struct packed {
    logic [2:0] kind;   // {data_valid, parity_err, frame_err}
    logic [7:0] data;
    logic       rel;
    logic       ext;
  } ev_t;

  ev_t        exp_q[$];
  int         n_checks;
  int         n_fail;
  logic [7:0] exp_rx;
  logic       m_ext;
  logic       m_brk;

  ps2_host_rx #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .rx_data    (rx_data),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .key_release(key_release),
    .key_ext    (key_ext)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  // Monitor: every output pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    ev_t e;
    if (!reset && (data_valid || parity_err || frame_err)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: dv=%0b pe=%0b fe=%0b rx=%02h, no pulse expected",
                 data_valid, parity_err, frame_err, rx_data);
      end else begin
        e = exp_q.pop_front();
        if ({data_valid, parity_err, frame_err, rx_data, key_release, key_ext} !==
            {e.kind, e.data, e.rel, e.ext}) begin
          n_fail++;
          $display("FAIL pulse_match: got dv/pe/fe=%03b rx=%02h rel=%0b ext=%0b, want %03b rx=%02h rel=%0b ext=%0b",
                   {data_valid, parity_err, frame_err}, rx_data, key_release, key_ext,
                   e.kind, e.data, e.rel, e.ext);
        end
      end
    end
  end

  task automatic push_ev(input logic [2:0] kind, input logic [7:0] data,
                         input logic rel, input logic ext);
    ev_t e;
    e.kind = kind;
    e.data = data;
    e.rel  = rel;
    e.ext  = ext;
    exp_q.push_back(e);
  endtask

  // Reference model of what one complete frame should produce.
  task automatic model_byte(input logic [7:0] b, input logic par_ok, input logic stop_ok);
    if (!stop_ok) begin
      push_ev(3'b001, exp_rx, 1'b0, 1'b0);
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (!par_ok) begin
      exp_rx = b;
      push_ev(3'b010, b, 1'b0, 1'b0);
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else begin
      exp_rx = b;
`ifdef PS2_BREAK_DECODE_EN
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
        push_ev(3'b100, b, m_brk, m_ext);
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
`else
      push_ev(3'b100, b, 1'b0, 1'b0);
`endif
    end
  endtask

  // One PS/2 bit: clock high 3 cycles (data changes 1 cycle in), low 3 cycles.
  task automatic send_bit(input logic b, input logic glitch);
    ps2_clk = 1'b1;
    @(negedge clk);
    ps2_dat = b;
    repeat (2) @(negedge clk);
    if (glitch) begin
      ps2_clk = 1'b0;
      @(negedge clk);
      ps2_clk = 1'b1;
      repeat (3) @(negedge clk);
    end
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop,
                            input int nbits, input int glitch_at);
    logic [10:0] fr;
    fr = {stop, (~^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(fr[i], i == glitch_at);
    if (nbits == 11) begin
      ps2_clk = 1'b1;
      ps2_dat = 1'b1;
      repeat (6) @(negedge clk);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d expected pulses never seen, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    exp_rx  = 8'h00;
    m_ext   = 1'b0;
    m_brk   = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({rx_data, data_valid, parity_err, frame_err, key_release, key_ext} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rx=%02h dv=%0b pe=%0b fe=%0b rel=%0b ext=%0b, want all 0",
               rx_data, data_valid, parity_err, frame_err, key_release, key_ext);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({rx_data, data_valid, parity_err, frame_err} !== 11'd0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got rx=%02h dv=%0b pe=%0b fe=%0b, want all 0",
               rx_data, data_valid, parity_err, frame_err);
    end
  endtask

  task automatic test_good_frame();
    int lat;
    model_byte(8'h1C, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1, 10, -1);
    send_bit_high_only();
    ps2_clk = 1'b0;
    lat = 0;
    while (!data_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat !== 6) begin
      n_fail++;
      $display("FAIL stop_to_valid_latency: got %0d cycles, want 6", lat);
    end
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (6) @(negedge clk);
    wait_drain("good_frame");
  endtask

  // High phase of the STOP bit; the falling edge is driven by the caller.
  task automatic send_bit_high_only();
    ps2_clk = 1'b1;
    @(negedge clk);
    ps2_dat = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_parity_err();
    model_byte(8'h1C, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b1, 1'b1, 11, -1);
    wait_drain("parity_err");
  endtask

  task automatic test_frame_err();
    model_byte(8'h29, 1'b1, 1'b0);
    send_frame(8'h29, 1'b0, 1'b0, 11, -1);
    wait_drain("frame_err");
  endtask

  task automatic test_timeout();
    push_ev(3'b001, exp_rx, 1'b0, 1'b0);
    m_ext = 1'b0;
    m_brk = 1'b0;
    send_frame(8'h0A, 1'b0, 1'b1, 5, -1);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    repeat (TIMEOUT + 10) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL timeout_abort: %0d pending, want frame_err within %0d cycles",
               exp_q.size(), TIMEOUT + 10);
      exp_q.delete();
    end
    model_byte(8'h29, 1'b1, 1'b1);
    send_frame(8'h29, 1'b0, 1'b1, 11, -1);
    wait_drain("after_timeout");
  endtask

  task automatic test_glitch();
    ps2_dat = 1'b0;
    @(negedge clk);
    ps2_clk = 1'b0;
    @(negedge clk);
    ps2_clk = 1'b1;
    repeat (2) @(negedge clk);
    ps2_dat = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++;
    if (dut.state !== 2'd0 && exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL idle_glitch: receiver left idle (state=%0d), want idle", dut.state);
    end
    model_byte(8'h1C, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 4);
    wait_drain("midframe_glitch");
  endtask

  task automatic test_break_seq();
    model_byte(8'hF0, 1'b1, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1, 11, -1);
    model_byte(8'h1C, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
    wait_drain("break_seq");
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [5];
    seq = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h6B};
    for (int i = 0; i < 5; i++) begin
      model_byte(seq[i], 1'b1, 1'b1);
      send_frame(seq[i], 1'b0, 1'b1, 11, -1);
    end
    wait_drain("back_to_back");
    n_checks++;
    if (rx_data !== 8'h6B) begin
      n_fail++;
      $display("FAIL back_to_back_rx: got %02h, want 6b", rx_data);
    end
  endtask

  task automatic test_reset_midframe();
    send_frame(8'h1C, 1'b0, 1'b1, 4, -1);
    reset   = 1'b1;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    exp_rx  = 8'h00;
    m_ext   = 1'b0;
    m_brk   = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({rx_data, data_valid, parity_err, frame_err} !== 11'd0) begin
      n_fail++;
      $display("FAIL midframe_reset: got rx=%02h dv=%0b pe=%0b fe=%0b, want all 0",
               rx_data, data_valid, parity_err, frame_err);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    model_byte(8'h1C, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
    wait_drain("after_reset");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_good_frame();
    test_parity_err();
    test_frame_err();
    test_timeout();
    test_glitch();
    test_break_seq();
    test_back_to_back();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
